products_8: RTL and testbench
=============================

Name: products_8

Overview:
- Registered partial-product row generator for the FPU mantissa multiplier.
- Gates an 8-bit multiplicand word by a single multiplier bit: out = in1 AND {8{in2}}.
- Forms one row of the partial-product array, which feeds the adder tree downstream.
- Single clock domain, one-cycle latency, with a valid qualifier and a zero flag for the adder tree.

Parameters:
- WIDTH, 8, multiplicand width and partial-product width in bits. Must be ≥ 1. All behaviour below is written for the default.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  qualifies in1/in2 this cycle.
- in1  input  WIDTH  multiplicand word, unsigned.
- in2  input  1  multiplier bit selecting this row.
- out  output  WIDTH  registered partial product.
- out_valid  output  1  out holds a product computed from a valid input.
- out_zero  output  1  registered flag: out is all zeros.

Behaviour:
- Reset
  - When rst_n=0 at a rising edge: out=0, out_valid=0, out_zero=1.
  - Reset overrides in_valid in the same cycle.
  - Reset is synchronous only; asserting rst_n between edges has no effect until the next edge.
- Function
  - Combinational product: p[i] = in1[i] & in2 for i = 0..WIDTH-1.
  - No carries, no sign handling, no width growth.
- Latency
  - On each rising edge with rst_n=1 and in_valid=1: out <= p, out_zero <= (p == 0), out_valid <= 1.
  - Product appears exactly 1 cycle after the inputs are sampled.
- Hold
  - On a rising edge with rst_n=1 and in_valid=0: out and out_zero hold their previous values, out_valid <= 0.
- Back-to-back operation
  - Continuous in_valid=1 gives one result per cycle; there is no stall or backpressure.
- Boundary cases
  - in2=0 → out=0 and out_zero=1, for any in1.
  - in2=1 → out=in1, and out_zero=1 only if in1=0.
  - in1=8'hFF with in2=1 → out=8'hFF.
- X-handling
  - in1 and in2 are don't-care when in_valid=0; they must not propagate to out.
- Synthesis
  - No latches.
  - out, out_valid and out_zero are driven directly from flops.

Decomposition:
- Shared FPU package holds the mantissa-row width constant (default 8), used as the WIDTH default.
- One natural combinational sub-module: pp_and_row, a WIDTH-bit AND of a word with a replicated bit.
- products_8 wraps pp_and_row with the output registers, the valid pipeline and the zero detector.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1, in1=8'hA5, in2=1 → out=8'h00, out_valid=0, out_zero=1 throughout.
- Pass-through: in1=8'h3C, in2=1, in_valid=1 → next cycle out=8'h3C, out_valid=1, out_zero=0.
- Kill: in1=8'hFF, in2=0, in_valid=1 → next cycle out=8'h00, out_zero=1, out_valid=1.
- Sweep: starting from in1=0, in2=0, increment in1 by 1 and toggle in2 every cycle for 50 cycles.
  - Required: out equals the previous cycle's in1 when the previous in2=1, and 8'h00 otherwise.
  - Required: out_valid=1 every cycle after the first.
- Hold: after out=8'h81, drive in_valid=0 with in1=8'h00, in2=1 → out stays 8'h81, out_valid=0, out_zero=0.
- Mid-stream reset: during the sweep, pulse rst_n=0 for 1 cycle → out=8'h00, out_valid=0 on the following edge. Products resume 1 cycle after rst_n returns to 1.

Source files
------------

// File: rtl/products_8_pkg.sv
// Shared FPU mantissa-multiplier constants.
// The row width sets the default width of every partial-product row.
package products_8_pkg;

  localparam int MANT_ROW_W = 8;

endpackage : products_8_pkg

// File: rtl/products_8_pp_and_row.sv
// One partial-product row: a multiplicand word gated by a single multiplier bit.
// Purely combinational; the caller registers the result.
module pp_and_row #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_word,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_row
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign o_row[gi] = i_word[gi] & i_bit;
    end
  endgenerate

endmodule : pp_and_row

// File: rtl/products_8.sv
// Registered partial-product row generator with a valid qualifier and a zero flag.
// One-cycle latency; data and zero flag hold while no valid input arrives.
module products_8
  import products_8_pkg::*;
#(
  parameter int WIDTH = MANT_ROW_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in1,
  input  logic             in2,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             out_zero
);

  logic [WIDTH-1:0] w_prod;
  logic             w_prod_zero;
  logic [WIDTH-1:0] r_out;
  logic             r_valid;
  logic             r_zero;

  pp_and_row #(
    .WIDTH (WIDTH)
  ) u_row (
    .i_word (in1),
    .i_bit  (in2),
    .o_row  (w_prod)
  );

  assign w_prod_zero = (w_prod == '0);

  // Data only loads on valid so don't-care inputs never reach the output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out   <= '0;
      r_valid <= 1'b0;
      r_zero  <= 1'b1;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_out  <= w_prod;
        r_zero <= w_prod_zero;
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_valid;
  assign out_zero  = r_zero;

endmodule : products_8

// File: tb/tb_products_8.sv
// Directed bench for products_8: a per-cycle reference model plus literal checks.
module tb_products_8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in1;
  logic       in2;
  logic [7:0] out;
  logic       out_valid;
  logic       out_zero;

  int total = 0;
  int bad   = 0;

  // Reference state: what the row must show after each edge.
  logic [7:0] m_out   = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_zero  = 1'b1;

  products_8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in1       (in1),
    .in2       (in2),
    .out       (out),
    .out_valid (out_valid),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  // Model: a selected row copies the multiplicand, an unselected row is zero.
  initial begin
    logic       s_rst;
    logic       s_v;
    logic [7:0] s_a;
    logic       s_b;
    forever begin
      @(posedge clk);
      s_rst = rst_n;
      s_v   = in_valid;
      s_a   = in1;
      s_b   = in2;
      #1;
      if (!s_rst) begin
        m_out   = 8'h00;
        m_valid = 1'b0;
        m_zero  = 1'b1;
      end else if (s_v) begin
        m_out   = s_b ? s_a : 8'h00;
        m_valid = 1'b1;
        m_zero  = (m_out == 8'h00);
      end else begin
        m_valid = 1'b0;
      end
      total++;
      if (out !== m_out || out_valid !== m_valid || out_zero !== m_zero) begin
        bad++;
        $display("FAIL model t=%0t: got out=%h v=%b z=%b, want out=%h v=%b z=%b",
                 $time, out, out_valid, out_zero, m_out, m_valid, m_zero);
      end
    end
  end

  task automatic step(input logic r, input logic v, input logic [7:0] a, input logic b);
    rst_n    = r;
    in_valid = v;
    in1      = a;
    in2      = b;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] e_out, input logic e_v, input logic e_z);
    total++;
    if (out !== e_out || out_valid !== e_v || out_zero !== e_z) begin
      bad++;
      $display("FAIL %s: got out=%h v=%b z=%b, want out=%h v=%b z=%b",
               name, out, out_valid, out_zero, e_out, e_v, e_z);
    end else begin
      $display("ok   %s: out=%h v=%b z=%b", name, out, out_valid, out_zero);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in1      = 8'hA5;
    in2      = 1'b1;

    step(1'b0, 1'b1, 8'hA5, 1'b1);
    chk("reset_1", 8'h00, 1'b0, 1'b1);
    step(1'b0, 1'b1, 8'hA5, 1'b1);
    chk("reset_2", 8'h00, 1'b0, 1'b1);

    step(1'b1, 1'b1, 8'h3C, 1'b1);
    chk("pass_3c", 8'h3C, 1'b1, 1'b0);
    step(1'b1, 1'b1, 8'hFF, 1'b0);
    chk("kill_ff", 8'h00, 1'b1, 1'b1);
    step(1'b1, 1'b1, 8'hFF, 1'b1);
    chk("pass_ff", 8'hFF, 1'b1, 1'b0);
    step(1'b1, 1'b1, 8'h00, 1'b1);
    chk("zero_in1", 8'h00, 1'b1, 1'b1);

    // Sweep with a one-cycle reset pulse in the middle.
    for (int i = 0; i < 50; i++) begin
      if (i == 25) begin
        step(1'b0, 1'b1, 8'(i), i[0]);
        chk("sweep_rst", 8'h00, 1'b0, 1'b1);
      end else begin
        step(1'b1, 1'b1, 8'(i), i[0]);
      end
      if (i == 7)  chk("sweep_07", 8'h07, 1'b1, 1'b0);
      if (i == 8)  chk("sweep_08", 8'h00, 1'b1, 1'b1);
      if (i == 27) chk("sweep_resume", 8'h1B, 1'b1, 1'b0);
    end

    step(1'b1, 1'b1, 8'h81, 1'b1);
    chk("load_81", 8'h81, 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    chk("hold_1", 8'h81, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    chk("hold_2", 8'h81, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h42, 1'b0);
    chk("after_hold", 8'h00, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_products_8
